rv_pipe_stage_reg: RTL
======================

// Module: rv_pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register for the RV32 pipeline: one stage holding a
//  packed payload with valid/ready handshake, stall, flush and bubble injection.
//  Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Instantiate with WIDTH=$bits(<stage struct>) and BUBBLE=<stage bubble constant> from rv32_pkg.
//  Tracks idle-output (bubble) cycles for CPI profiling.
// PARAMETERS
//  WIDTH   32   payload width in bits
//  BUBBLE  '0   WIDTH-bit value driven on out_data whenever out_valid=0
//  CNT_W   16   width of the saturating bubble counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush_i    in   1      invalidate all held entries
//  stall_i    in   1      freeze output side (hazard hold)
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      downstream payload valid
//  out_ready  in   1      downstream can accept
//  out_data   out  WIDTH  payload, or BUBBLE when not valid
//  bubble_cnt out  CNT_W  count of cycles with out_ready=1 and out_valid=0
// BEHAVIOUR
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Data: out_data is registered; no combinational path from in_data to out_data.
//  - Latency: 1 cycle from in_fire to out_valid.
//  - Upstream rule: in_data must stay stable while in_valid=1 and in_ready=0.
//  - Reset (async): state EMPTY, out_valid=0, out_data=BUBBLE, bubble_cnt=0.
//    in_ready is forced to 0 while rst=1.
//  - Output masking:
//    - out_valid = entry_valid & ~stall_i. Held data is kept during stall.
//    - Stall never drops or duplicates a beat.
//  - Flush:
//    - All entries are invalid next cycle and out_data=BUBBLE.
//    - An in_fire in the flush cycle is dropped.
//    - Priority: flush > stall > normal transfer.
//  - States:
//    - EMPTY: in_fire -> FULL1.
//    - FULL1: in_fire & ~out_fire -> FULL2 (skid build only; otherwise impossible).
//    - FULL1: out_fire & ~in_fire -> EMPTY.
//    - FULL1: in_fire & out_fire -> FULL1, new data loaded.
//    - FULL2: out_fire -> FULL1, skid entry moves to main; in_ready=0 in FULL2.
//    - Any state: flush -> EMPTY.
//  - Order: strict FIFO; at most one beat in and one beat out per cycle.
//  - bubble_cnt: +1 on each cycle with out_ready & ~out_valid.
//    Saturates at 2^CNT_W-1; cleared only by rst.
//  - Reset mid-transfer: entries are discarded; no output beat is produced for them.
// CONFIGURATION
//  RV_PIPE_SKID_EN defined:
//   - Two entries (main + skid).
//   - in_ready is registered = (state != FULL2); no combinational out_ready->in_ready path.
//   - Full throughput under single-cycle backpressure.
//  RV_PIPE_SKID_EN undefined:
//   - Single entry; FULL2 does not exist.
//   - in_ready = ~rst & (~entry_valid | (out_ready & ~stall_i)), combinational.
// TESTING
//  1 rst=1 for 3 cycles -> out_valid=0, out_data=BUBBLE, in_ready=0, bubble_cnt=0.
//  2 Stream 0x1..0x8, out_ready=1 -> 0x1..0x8 out in order, 1-cycle latency, no gaps.
//  3 SKID_EN, 0xA then 0xB accepted, out_ready=0 -> in_ready=0 next cycle.
//    Release -> 0xA then 0xB, none lost.
//  4 Holding 0x33, flush_i=1 with in_valid=1 (0x44) -> next cycle out_valid=0,
//    out_data=BUBBLE; 0x44 never emitted.
//  5 Holding 0x55, stall_i=1 for 4 cycles -> out_valid=0 throughout.
//    Release -> 0x55 emitted exactly once.
//  6 CNT_W=4, idle with out_ready=1 for 20 cycles -> bubble_cnt=15 and holds.

Source files
------------

// File: rtl/rv_pipe_stage_reg.sv
// Elastic pipeline register: valid/ready handshake with stall, flush and a bubble counter.
// Define RV_PIPE_SKID_EN for the two-entry build with a registered in_ready.
module rv_pipe_stage_reg #(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int              CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL1 = 2'd1;
`ifdef RV_PIPE_SKID_EN
  localparam logic [1:0] ST_FULL2 = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             entry_valid, in_fire, out_fire;
  logic [CNT_W-1:0] bubble_q;

  assign entry_valid = (state_q != ST_EMPTY);
  assign out_valid   = entry_valid & ~stall_i;
  assign out_fire    = out_valid & out_ready;
  assign in_fire     = in_valid & in_ready;
  // Output mux only selects between held state and a constant; in_data never reaches it.
  assign out_data    = out_valid ? main_q : BUBBLE;
  assign bubble_cnt  = bubble_q;

`ifdef RV_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;

  // Decoded from the state register only, so out_ready has no path to in_ready.
  assign in_ready = ~rst & (state_q != ST_FULL2);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_FULL1;
          main_d  = in_data;
        end
        ST_FULL1: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL2;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL2: if (out_fire) begin
          state_d = ST_FULL1;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skid_q <= BUBBLE;
    else     skid_q <= skid_d;
  end
`else
  assign in_ready = ~rst & (~entry_valid | (out_ready & ~stall_i));

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_FULL1;
          main_d  = in_data;
        end
        ST_FULL1: begin
          if (in_fire)       main_d  = in_data;
          else if (out_fire) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // Idle-output profiling counter; saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_q <= '0;
    else if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}}))
      bubble_q <= bubble_q + CNT_W'(1);
  end

endmodule
